// File: rtl/multicycle_control.sv
// Multi-cycle sequencing control: fetch handshake, decode of the latched opcode/func,
// and EXEC / MEM / MULDIV / WB sequencing that drives the datapath control strobes.
module multicycle_control #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16,
    parameter int CNTW       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [3:0] opcode,
    input  logic [3:0] func,
    input  logic       mem_ready,
    output logic       instr_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] bType,
    output logic [1:0] rWrite,
    output logic [1:0] useFunc,
    output logic       mWrite,
    output logic       mRead,
    output logic       mByte,
    output logic       j,
    output logic       offsetSel,
    output logic       alu_start,
    output logic       illegal,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_MULDIV = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [CNTW-1:0] MUL_LOAD = CNTW'(MUL_CYCLES - 1);
    localparam logic [CNTW-1:0] DIV_LOAD = CNTW'(DIV_CYCLES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_op;
    logic [3:0]      r_func;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_next;

    logic w_rtype, w_mul, w_div, w_func_ok, w_op_undef, w_illegal;
    logic w_mem, w_load, w_swap;

    // Decode works only on the latched IR fields, never on the live inputs.
    assign w_rtype    = (r_op == 4'b0000);
    assign w_mul      = w_rtype && (r_func == 4'b0100);
    assign w_div      = w_rtype && (r_func == 4'b1000);
    assign w_func_ok  = (r_func == 4'b0000) || (r_func == 4'b0001) || (r_func == 4'b0100) ||
                        (r_func == 4'b1000) || (r_func == 4'b1110) || (r_func == 4'b1111);
    assign w_op_undef = (r_op == 4'b0011) || (r_op == 4'b0111) ||
                        (r_op == 4'b1101) || (r_op == 4'b1110);
    assign w_illegal  = w_op_undef || (w_rtype && !w_func_ok);
    assign w_mem      = (r_op[3:2] == 2'b10);
    assign w_load     = w_mem && !r_op[0];
    assign w_swap     = w_rtype && (r_func == 4'b1111);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_func  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_FETCH && instr_valid) begin
                r_op   <= opcode;
                r_func <= func;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        instr_ready = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        bType       = 2'b00;
        rWrite      = 2'b00;
        useFunc     = 2'b00;
        mWrite      = 1'b0;
        mRead       = 1'b0;
        mByte       = 1'b0;
        j           = 1'b0;
        offsetSel   = 1'b0;
        alu_start   = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                instr_ready = 1'b1;
                ir_write    = instr_valid;
                if (instr_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_mul || w_div) begin
                    w_cnt_next = w_mul ? MUL_LOAD : DIV_LOAD;
                    alu_start  = 1'b1;
                    w_next     = S_MULDIV;
                end else if (w_mem) begin
                    w_next = S_MEM;
                end else if (r_op == 4'b1111) begin
                    w_next = S_HALT;
                end else begin
                    illegal = w_illegal;
                    w_next  = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_write = 1'b1;
                w_next   = S_FETCH;
                if (!w_illegal) begin
                    case (r_op)
                        4'b0000: begin
                            rWrite = 2'b01;
                            if (w_swap) w_next = S_WB;
                        end
                        4'b0001: begin
                            rWrite    = 2'b01;
                            useFunc   = 2'b01;
                            offsetSel = 1'b1;
                        end
                        4'b0010: begin
                            rWrite    = 2'b10 - 2'b01;
                            useFunc   = 2'b10;
                            offsetSel = 1'b1;
                        end
                        4'b0100: bType = 2'b01;
                        4'b0101: bType = 2'b10;
                        4'b0110: bType = 2'b11;
                        4'b1100: j     = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                // Request stays asserted unchanged until memory reports completion.
                useFunc   = 2'b11;
                offsetSel = 1'b1;
                mRead     = w_load;
                mWrite    = !w_load;
                mByte     = !r_op[1];
                if (mem_ready) begin
                    if (w_load) begin
                        w_next = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        w_next   = S_FETCH;
                    end
                end
            end
            S_MULDIV: begin
                if (r_cnt == '0) w_next = S_WB;
                else             w_cnt_next = r_cnt - 1'b1;
            end
            S_WB: begin
                w_next = S_FETCH;
                // Swap's PC already advanced in EXEC, so its second write leaves the PC alone.
                if (w_swap) begin
                    rWrite = 2'b11;
                end else if (w_load) begin
                    rWrite   = 2'b10;
                    pc_write = 1'b1;
                end else begin
                    rWrite   = 2'b01;
                    pc_write = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected traces built from instruction-level
// rules, driven with randomized instruction mixes plus directed corner cases.
module tb_multicycle_control;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 16;
    localparam int CNTW       = 5;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [3:0] func;
    logic       mem_ready;
    logic       instr_ready, ir_write, pc_write;
    logic [1:0] bType, rWrite, useFunc;
    logic       mWrite, mRead, mByte, j, offsetSel, alu_start, illegal, halted;
    logic [2:0] state;

    typedef struct packed {
        logic       instr_ready;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] bType;
        logic [1:0] rWrite;
        logic [1:0] useFunc;
        logic       mWrite;
        logic       mRead;
        logic       mByte;
        logic       j;
        logic       offsetSel;
        logic       alu_start;
        logic       illegal;
        logic       halted;
        logic [2:0] state;
    } out_t;

    typedef struct packed {
        logic       iv;
        logic       mr;
        logic [3:0] op;
        logic [3:0] fn;
    } stim_t;

    out_t        w_obs;
    logic [19:0] exp_q[$];
    stim_t       stim_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    assign w_obs = {instr_ready, ir_write, pc_write, bType, rWrite, useFunc,
                    mWrite, mRead, mByte, j, offsetSel, alu_start, illegal, halted, state};

    multicycle_control #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .CNTW      (CNTW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .func       (func),
        .mem_ready  (mem_ready),
        .instr_ready(instr_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .bType      (bType),
        .rWrite     (rWrite),
        .useFunc    (useFunc),
        .mWrite     (mWrite),
        .mRead      (mRead),
        .mByte      (mByte),
        .j          (j),
        .offsetSel  (offsetSel),
        .alu_start  (alu_start),
        .illegal    (illegal),
        .halted     (halted),
        .state      (state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rn();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic out_t st_only(input logic [2:0] s);
        out_t e;
        e       = '0;
        e.state = s;
        return e;
    endfunction

    task automatic check(input string tag, input logic [19:0] o, input logic [19:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic push_cyc(input logic iv, input logic mr, input logic [3:0] op,
                            input logic [3:0] fn, input out_t e);
        stim_t s;
        s = {iv, mr, op, fn};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        out_t e;
        e             = st_only(3'd0);
        e.instr_ready = 1'b1;
        push_cyc(1'b0, rb(), rn(), rn(), e);
    endtask

    // Reference: expected per-cycle trace of one instruction, from the instruction's class.
    task automatic gen_instr(input logic [3:0] op, input logic [3:0] fn, input int w);
        out_t e;
        logic ill, md, mem, ld, byt;
        int   n;
        ill = (op inside {4'd3, 4'd7, 4'd13, 4'd14}) ||
              (op == 4'd0 && !(fn inside {4'd0, 4'd1, 4'd4, 4'd8, 4'd14, 4'd15}));
        md  = (op == 4'd0) && (fn == 4'd4 || fn == 4'd8);
        mem = (op >= 4'd8) && (op <= 4'd11);
        ld  = (op == 4'd8) || (op == 4'd10);
        byt = (op == 4'd8) || (op == 4'd9);

        e = st_only(3'd0); e.instr_ready = 1'b1; e.ir_write = 1'b1;
        push_cyc(1'b1, rb(), op, fn, e);
        e = st_only(3'd1); e.alu_start = md; e.illegal = ill;
        push_cyc(rb(), rb(), rn(), rn(), e);

        if (op == 4'd15) begin
            for (int i = 0; i < 20; i++) begin
                e = st_only(3'd6); e.halted = 1'b1;
                push_cyc(1'b1, rb(), rn(), rn(), e);
            end
        end else if (md) begin
            n = (fn == 4'd4) ? MUL_CYCLES : DIV_CYCLES;
            for (int i = 0; i < n; i++) push_cyc(rb(), rb(), rn(), rn(), st_only(3'd4));
            e = st_only(3'd5); e.rWrite = 2'b01; e.pc_write = 1'b1;
            push_cyc(rb(), rb(), rn(), rn(), e);
        end else if (mem) begin
            e = st_only(3'd3);
            e.useFunc = 2'b11; e.offsetSel = 1'b1;
            e.mRead = ld; e.mWrite = !ld; e.mByte = byt;
            for (int i = 0; i < w; i++) push_cyc(rb(), 1'b0, rn(), rn(), e);
            e.pc_write = !ld;
            push_cyc(rb(), 1'b1, rn(), rn(), e);
            if (ld) begin
                e = st_only(3'd5); e.rWrite = 2'b10; e.pc_write = 1'b1;
                push_cyc(rb(), rb(), rn(), rn(), e);
            end
        end else begin
            e = st_only(3'd2); e.pc_write = 1'b1;
            if (!ill) begin
                case (op)
                    4'd0:  e.rWrite = 2'b01;
                    4'd1:  begin e.rWrite = 2'b01; e.useFunc = 2'b01; e.offsetSel = 1'b1; end
                    4'd2:  begin e.rWrite = 2'b01; e.useFunc = 2'b10; e.offsetSel = 1'b1; end
                    4'd4:  e.bType = 2'b01;
                    4'd5:  e.bType = 2'b10;
                    4'd6:  e.bType = 2'b11;
                    4'd12: e.j = 1'b1;
                    default: ;
                endcase
            end
            push_cyc(rb(), rb(), rn(), rn(), e);
            if (op == 4'd0 && fn == 4'd15) begin
                e = st_only(3'd5); e.rWrite = 2'b11;
                push_cyc(rb(), rb(), rn(), rn(), e);
            end
        end
    endtask

    // Driver: inputs at negedge, outputs compared 1 time unit later, well before posedge.
    task automatic run_n(input int n);
        stim_t       s;
        logic [19:0] e;
        for (int i = 0; i < n && stim_q.size() > 0; i++) begin
            @(negedge clk);
            s           = stim_q.pop_front();
            instr_valid = s.iv;
            mem_ready   = s.mr;
            opcode      = s.op;
            func        = s.fn;
            #1;
            e = exp_q.pop_front();
            check($sformatf("trace_cyc%0d", cyc), w_obs, e);
            cyc++;
        end
    endtask

    task automatic run_all();
        run_n(stim_q.size());
    endtask

    task automatic do_reset(input string tag);
        out_t e;
        stim_q.delete();
        exp_q.delete();
        #2;
        reset       = 1'b0;
        instr_valid = 1'b0;
        #1;
        e = st_only(3'd0); e.instr_ready = 1'b1;
        check(tag, w_obs, e);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [3:0] valid_fn [6] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd14, 4'd15};

    initial begin
        out_t       e;
        logic [3:0] op, fn;
        reset       = 1'b0;
        instr_valid = 1'b0;
        opcode      = '0;
        func        = '0;
        mem_ready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        e = st_only(3'd0); e.instr_ready = 1'b1;
        check("reset_state", w_obs, e);
        reset = 1'b1;

        // Directed: add x2 back-to-back, lw with 3 waits, sb, mult, div, swap, beq, j, undefined 0111
        gen_instr(4'd0, 4'd0, 0);
        gen_instr(4'd0, 4'd0, 0);
        gen_instr(4'd10, 4'd0, 3);
        gen_instr(4'd9, 4'd0, 0);
        gen_instr(4'd0, 4'd4, 0);
        gen_instr(4'd0, 4'd8, 0);
        gen_instr(4'd0, 4'd15, 0);
        gen_instr(4'd6, 4'd0, 0);
        gen_instr(4'd12, 4'd0, 0);
        gen_instr(4'd7, 4'd0, 0);
        gen_instr(4'd0, 4'd2, 0);
        run_all();

        // Reset mid-div aborts; no writeback may follow.
        gen_instr(4'd0, 4'd8, 0);
        run_n(7);
        do_reset("reset_mid_div");
        for (int i = 0; i < 22; i++) push_idle();
        run_all();

        // Randomized instruction mix.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) push_idle();
            op = rn();
            if (op == 4'd15) op = 4'd0;
            fn = ($urandom_range(0, 1) == 1) ? valid_fn[$urandom_range(0, 5)] : rn();
            gen_instr(op, fn, int'($urandom_range(0, 4)));
            run_all();
        end

        // HALT holds 20 cycles with instr_valid high, then only reset exits.
        gen_instr(4'd15, 4'd0, 0);
        run_all();
        do_reset("reset_from_halt");
        gen_instr(4'd0, 4'd1, 0);
        run_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
